// File: rtl/sd_pkg.sv
// Shared encodings and framing constants for the SD command-line controller.
package sd_pkg;

    localparam logic [1:0] RESP_NONE     = 2'b00;
    localparam logic [1:0] RESP_48_CRC   = 2'b01;
    localparam logic [1:0] RESP_48_NOCRC = 2'b10;
    localparam logic [1:0] RESP_136      = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RECV = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam int CMD_BITS = 48;
    localparam int R2_BITS  = 136;
    localparam int NCR_MAX  = 64;
    localparam int NCC_BITS = 8;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, synchronous clear to zero.
module sd_crc7 (
    input  logic       ctrl_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'd0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

    always_ff @(posedge ctrl_clk or posedge rst) begin
        if (rst) crc_q <= 7'd0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line controller: sends a 48-bit command frame and captures the card response.
// Define SD_CMD_CRC_CHECK_EN to check response CRC7; otherwise crc_err is constant 0.
//
// state | meaning
// IDLE  | waiting for start
// SEND  | driving the 48-bit command, MSB first
// WAIT  | listening for the response start bit (up to NCR_MAX bit periods)
// RECV  | shifting in the rest of the response
// GAP   | NCC_BITS bit periods of bus turnaround, busy still high
module sd_cmd_ctrl
    import sd_pkg::*;
(
    input  logic         ctrl_clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         busy,
    output logic         done,
    output logic [127:0] resp_data,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         end_err,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in
);

    logic [2:0]   state_q, state_d;
    logic         phase_q, phase_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [47:0]  tx_sr_q, tx_sr_d;
    logic [126:0] rx_sr_q, rx_sr_d;
    logic [1:0]   rtype_q, rtype_d;
    logic [127:0] resp_q, resp_d;
    logic         done_q, done_d;
    logic         timeout_q, timeout_d;
    logic         crc_err_q, crc_err_d;
    logic         end_err_q, end_err_d;

    logic         accept;
    logic [6:0]   tx_crc;
    logic         tx_bit;
    logic [127:0] rx_full;
    logic         crc_mismatch;

    assign accept  = (state_q == ST_IDLE) && start;
    assign rx_full = {rx_sr_q, cmd_in};

    sd_crc7 u_tx_crc (
        .ctrl_clk (ctrl_clk),
        .rst      (rst),
        .clr      (accept),
        .en       ((state_q == ST_SEND) && phase_q && (cnt_q >= 8'd8)),
        .din      (tx_sr_q[47]),
        .crc      (tx_crc)
    );

    // During the seven CRC bit slots the shift register is bypassed by the frozen CRC.
    assign tx_bit = ((cnt_q != 8'd0) && (cnt_q < 8'd8)) ? tx_crc[cnt_q[2:0] - 3'd1] : tx_sr_q[47];

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc;

    sd_crc7 u_rx_crc (
        .ctrl_clk (ctrl_clk),
        .rst      (rst),
        .clr      (accept),
        .en       (phase_q && (((state_q == ST_WAIT) && !cmd_in) ||
                   ((state_q == ST_RECV) && (cnt_q >= 8'd8) && (rtype_q != RESP_136)))),
        .din      (cmd_in),
        .crc      (rx_crc)
    );

    assign crc_mismatch = (rtype_q == RESP_48_CRC) && (rx_crc != rx_sr_q[6:0]);
`else
    assign crc_mismatch = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = (state_q == ST_IDLE) ? 1'b0 : ~phase_q;
        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rtype_d   = rtype_q;
        resp_d    = resp_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SEND;
                    cnt_d     = 8'(CMD_BITS - 1);
                    tx_sr_d   = {2'b01, cmd_index, cmd_arg, 8'hFF};
                    rtype_d   = resp_type;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (phase_q) begin
                    if (cnt_q == 8'd0) begin
                        if (rtype_q == RESP_NONE) begin
                            state_d = ST_GAP;
                            cnt_d   = 8'(NCC_BITS - 1);
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = 8'(NCR_MAX - 1);
                        end
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        tx_sr_d = {tx_sr_q[46:0], 1'b1};
                    end
                end
            end
            ST_WAIT: begin
                if (phase_q) begin
                    if (!cmd_in) begin
                        state_d = ST_RECV;
                        rx_sr_d = {rx_sr_q[125:0], cmd_in};
                        cnt_d   = (rtype_q == RESP_136) ? 8'(R2_BITS - 2) : 8'(CMD_BITS - 2);
                    end else if (cnt_q == 8'd0) begin
                        state_d   = ST_GAP;
                        cnt_d     = 8'(NCC_BITS - 1);
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_RECV: begin
                if (phase_q) begin
                    rx_sr_d = {rx_sr_q[125:0], cmd_in};
                    if (cnt_q == 8'd0) begin
                        state_d   = ST_GAP;
                        cnt_d     = 8'(NCC_BITS - 1);
                        done_d    = 1'b1;
                        end_err_d = !cmd_in;
                        crc_err_d = crc_mismatch;
                        resp_d    = (rtype_q == RESP_136) ? rx_full : {90'd0, rx_full[45:8]};
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (phase_q) begin
                    if (cnt_q == 8'd0) state_d = ST_IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= 8'd0;
            tx_sr_q   <= '1;
            rx_sr_q   <= '0;
            rtype_q   <= RESP_NONE;
            resp_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rtype_q   <= rtype_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign cmd_oe      = (state_q == ST_SEND);
    assign cmd_out     = (state_q == ST_SEND) ? tx_bit : 1'b1;
    assign resp_data   = resp_q;
    assign timeout_err = timeout_q;
    assign crc_err     = crc_err_q;
    assign end_err     = end_err_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Randomized self-checking bench for sd_cmd_ctrl with a timeline-level reference model and card model.
module tb_sd_cmd_ctrl;

    logic         ctrl_clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         busy, done, timeout_err, crc_err, end_err, cmd_out, cmd_oe;
    logic [127:0] resp_data;
    logic         cmd_in = 1'b1;

    sd_cmd_ctrl dut (
        .ctrl_clk    (ctrl_clk),
        .rst         (rst),
        .start       (start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .busy        (busy),
        .done        (done),
        .resp_data   (resp_data),
        .timeout_err (timeout_err),
        .crc_err     (crc_err),
        .end_err     (end_err),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .cmd_in      (cmd_in)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    int cyc = 0;
    always @(posedge ctrl_clk) cyc <= cyc + 1;

    // Expected timeline of the transaction in flight, relative to the cycle start was driven.
    bit           act = 1'b0;
    int           acc = 0;
    int           gs = 0;
    logic [47:0]  m_frame = '0;
    logic [127:0] m_resp = '0;
    logic         m_to = 1'b0, m_crc = 1'b0, m_end = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_model(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    always @(negedge ctrl_clk) begin : cmp
        int r;
        if (act && !rst) begin
            r = cyc - acc;
            if (r >= 1) begin
                chk("busy", busy, r < gs + 16);
                chk("done", done, r == gs);
                chk("cmd_oe", cmd_oe, r <= 96);
                chk("cmd_out", cmd_out, (r <= 96) ? m_frame[47 - (r - 1) / 2] : 1'b1);
                chk("resp_data", resp_data, (r >= gs) ? m_resp : 128'd0);
                chk("err_flags", {timeout_err, crc_err, end_err},
                    (r >= gs) ? {m_to, m_crc, m_end} : 3'b000);
            end
        end
    end

    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input int delay, input logic [135:0] rep, input int junk_r,
                           input int rst_r, output int done_at, output int idle_at,
                           output logic [47:0] cap);
        int           len, g, p;
        logic [127:0] er;
        logic         eto, ecrc, eend;
        bit           drive;
        len  = (rt == 2'b11) ? 136 : 48;
        drive = (rt != 2'b00) && (delay < 64);
        eto = 1'b0; ecrc = 1'b0; eend = 1'b0; er = '0;
        if (rt == 2'b00) begin
            g = 97;
        end else if (!drive) begin
            g   = 97 + 128;
            eto = 1'b1;
        end else begin
            g    = 97 + 2 * (delay + len);
            eend = ~rep[0];
            er   = (rt == 2'b11) ? rep[127:0] : {90'd0, rep[45:8]};
`ifdef SD_CMD_CRC_CHECK_EN
            if (rt == 2'b01) ecrc = (crc7_model(rep[47:8]) != rep[7:1]);
`endif
        end
        done_at = -1;
        idle_at = -1;
        cap = '1;
        @(negedge ctrl_clk);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        start     = 1'b1;
        m_frame = {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
        m_resp = er; m_to = eto; m_crc = ecrc; m_end = eend;
        gs = g; acc = cyc; act = 1'b1;
        for (int k = 1; k <= g + 18; k++) begin
            @(negedge ctrl_clk);
            start = (k == junk_r) && (k <= g + 14);
            if (start) begin
                cmd_index = 6'($urandom);
                cmd_arg   = $urandom;
                resp_type = 2'($urandom);
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (busy === 1'b0 && idle_at < 0) idle_at = k;
            if (k <= 96 && (k % 2) == 1) cap[47 - (k - 1) / 2] = cmd_out;
            p = (k - 97) / 2;
            if (drive && k >= 97 && p >= delay && (p - delay) < len)
                cmd_in = rep[len - 1 - (p - delay)];
            else
                cmd_in = 1'b1;
            if (k == rst_r) begin
                act = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_cmd_oe", cmd_oe, 1'b0);
                chk("rst_cmd_out", cmd_out, 1'b1);
                chk("rst_done", done, 1'b0);
                chk("rst_resp", resp_data, 128'd0);
                chk("rst_errs", {timeout_err, crc_err, end_err}, 3'b000);
                @(negedge ctrl_clk);
                rst = 1'b0;
                break;
            end
        end
        start  = 1'b0;
        cmd_in = 1'b1;
    endtask

    initial begin
        logic [47:0]  cap;
        logic [135:0] rep;
        logic [127:0] rnd;
        logic [39:0]  hdr;
        logic [6:0]   cf;
        logic [1:0]   rt;
        int           d, i, dl;

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_cmd_oe", cmd_oe, 1'b0);
        chk("reset_cmd_out", cmd_out, 1'b1);
        chk("reset_done", done, 1'b0);
        chk("reset_resp", resp_data, 128'd0);
        chk("reset_errs", {timeout_err, crc_err, end_err}, 3'b000);
        repeat (3) @(negedge ctrl_clk);
        rst = 1'b0;

        chk("model_crc_cmd0", crc7_model(40'h4000000000), 7'h4A);
        chk("model_crc_r7", crc7_model(40'h08000001AA), 7'h09);

        // CMD0, no response
        run_txn(6'd0, 32'd0, 2'b00, 0, '0, 0, 0, d, i, cap);
        chk("cmd0_frame", cap, 48'h400000000095);
        chk("cmd0_done_cycle", d, 97);
        chk("cmd0_idle_cycle", i, 113);
        chk("cmd0_errs", {timeout_err, crc_err, end_err}, 3'b000);

        // CMD8 with a clean R7 reply after 5 bit periods
        rep = 136'h08000001AA13;
        run_txn(6'd8, 32'h000001AA, 2'b01, 5, rep, 40, 0, d, i, cap);
        chk("cmd8_frame", cap, 48'h48000001AA87);
        chk("cmd8_resp", resp_data, 128'h08000001AA);
        chk("cmd8_errs", {timeout_err, crc_err, end_err}, 3'b000);
        chk("cmd8_done_cycle", d, 203);

        // Corrupted reply CRC byte 0x14 (also clears the end bit)
        rep = 136'h08000001AA14;
        run_txn(6'd8, 32'h000001AA, 2'b01, 5, rep, 0, 0, d, i, cap);
`ifdef SD_CMD_CRC_CHECK_EN
        chk("cmd8_bad_crc", crc_err, 1'b1);
`else
        chk("cmd8_bad_crc", crc_err, 1'b0);
`endif
        chk("cmd8_bad_end", end_err, 1'b1);
        chk("cmd8_bad_to", timeout_err, 1'b0);

        // No reply at all
        run_txn(6'd55, 32'hDEADBEEF, 2'b01, 100, '0, 150, 0, d, i, cap);
        chk("timeout_flag", timeout_err, 1'b1);
        chk("timeout_done_cycle", d, 225);
        chk("timeout_idle_cycle", i, 241);

        // R2 with end bit forced low
        rnd = {$urandom, $urandom, $urandom, $urandom};
        rep = {2'b00, 6'h3F, rnd[126:0], 1'b0};
        run_txn(6'd2, 32'd0, 2'b11, 2, rep, 0, 0, d, i, cap);
        chk("r2_end_err", end_err, 1'b1);
        chk("r2_resp", resp_data, rep[127:0]);

        // Reply start bit on the last listening period, then one period too late
        hdr = {2'b00, 38'($urandom) ^ {38'($urandom) << 6}};
        rep = {88'd0, hdr, crc7_model(hdr), 1'b1};
        run_txn(6'd13, $urandom, 2'b01, 63, rep, 0, 0, d, i, cap);
        chk("ncr_edge_to", timeout_err, 1'b0);
        run_txn(6'd13, $urandom, 2'b01, 64, rep, 0, 0, d, i, cap);
        chk("ncr_over_to", timeout_err, 1'b1);

        // Reset at command bit 20, then a fresh CMD0
        run_txn(6'd17, 32'h12345678, 2'b01, 3, rep, 0, 41, d, i, cap);
        run_txn(6'd0, 32'd0, 2'b00, 0, '0, 0, 0, d, i, cap);
        chk("post_rst_frame", cap, 48'h400000000095);
        chk("post_rst_done_cycle", d, 97);

        for (int n = 0; n < 40; n++) begin
            rt = 2'($urandom_range(0, 3));
            dl = $urandom_range(0, 70);
            if (rt == 2'b11) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                rep = {2'b00, 6'h3F, rnd[126:0], 1'($urandom_range(0, 3) != 0)};
            end else begin
                hdr = {2'b00, 6'($urandom), $urandom};
                cf  = crc7_model(hdr) ^ (($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0);
                rep = {88'd0, hdr, cf, 1'($urandom_range(0, 3) != 0)};
            end
            run_txn(6'($urandom), $urandom, rt, dl, rep, $urandom_range(2, 500), 0, d, i, cap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_cmd_ctrl.md
SD_CMD_CTRL -- requirements
Module: sd_cmd_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: `ctrl_clk` and `rst`.
- ctrl_clk  in  1  control clock; 2x the card clock (400 kHz in init mode, 48 MHz in fast mode).
- rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have the following command-side ports:
- start  in  1  single-cycle request to issue a command.
- cmd_index  in  6  command number.
- cmd_arg  in  32  command argument.
- resp_type  in  2  00 none, 01 48-bit with CRC, 10 48-bit without CRC (R3), 11 136-bit (R2).
- busy  out  1  transaction in progress.
- done  out  1  single-cycle completion pulse.
REQ-003 SHALL have the following response-side ports:
- resp_data  out  128  captured response.
- timeout_err  out  1  no response start bit seen.
- crc_err  out  1  response CRC7 mismatch.
- end_err  out  1  response end bit was 0.
REQ-004 SHALL have the following CMD-line ports:
- cmd_out  out  1  CMD line drive value.
- cmd_oe  out  1  CMD line output enable.
- cmd_in  in  1  CMD line sampled value.

Function
REQ-005 SHALL use a 1-bit phase toggle: one bit period = 2 ctrl_clk cycles; cmd_out changes only when phase=0; cmd_in is sampled only when phase=1.
REQ-006 SHALL implement states IDLE -> SEND -> (WAIT_RESP -> RECV) -> GAP -> IDLE; resp_type=00 goes from SEND directly to GAP.
REQ-007 In IDLE, start=1 SHALL be accepted; busy=1, cmd_oe=1 and phase=0 from the next cycle; cmd_index/cmd_arg/resp_type are latched at acceptance.
REQ-008 start SHALL be ignored while busy=1, and SHALL NOT alter latched fields.
REQ-009 SEND SHALL transmit 48 bits MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
- SEND lasts exactly 96 cycles.
- CRC7 polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
REQ-010 After SEND, cmd_oe SHALL be 0 and cmd_out SHALL be 1.
REQ-011 WAIT_RESP SHALL count bit periods; cmd_in=0 sampled at phase=1 SHALL enter RECV.
- The start bit counts as response bit 0.
- If 64 bit periods pass with no start bit: timeout_err=1, go to GAP.
REQ-012 RECV SHALL shift in the remaining bits (47 for short, 135 for R2), then check end bit = 1; a 0 end bit sets end_err=1.
REQ-013 Short response: resp_data[37:0] = response bits [45:8]; resp_data[127:38] = 0.
REQ-014 R2 response: resp_data[127:0] = response bits [127:0].
REQ-015 Short response CRC7 SHALL be computed over bits [47:8] and compared with bits [7:1].
- CRC checking is gated by REQ-020.
- CRC checking is never applied to resp_type 10 or 11.
REQ-016 On entry to GAP, done SHALL pulse for 1 cycle; error flags and resp_data are valid from that cycle and held until the next accepted start.
REQ-017 GAP SHALL last 8 bit periods (16 cycles) with cmd_oe=0; busy falls on the cycle after GAP ends.
REQ-018 Error flags SHALL clear on accepted start; they are mutually exclusive except crc_err+end_err, which may both be set.

Reset
REQ-019 rst=1 SHALL force the following immediately, including mid-transaction, with no done pulse:
- state=IDLE, phase=0, busy=0, done=0.
- cmd_oe=0, cmd_out=1.
- resp_data=0, all error flags=0.

Configuration
REQ-020 Macro SD_CMD_CRC_CHECK_EN SHALL control response CRC checking.
- Defined: REQ-015 checking is active.
- Undefined: the response CRC comparator is omitted and crc_err is tied to 0.
- Command CRC7 generation is always present.

Structure
REQ-021 A shared package `sd_pkg` SHALL hold:
- resp_type encodings.
- state encodings.
- constants CMD_BITS=48, R2_BITS=136, NCR_MAX=64, NCC_BITS=8.
REQ-022 The serial CRC7 logic SHALL be the sub-module `sd_crc7`.
- Ports: ctrl_clk, rst, clr, en, din, crc[6:0].
- Instantiated twice: command transmit and response receive.

Verification
REQ-023 CMD0: start, index 0, arg 0, type 00 -> cmd_out bit stream is 0x400000000095; done pulses at cycle 97 after acceptance; no errors.
REQ-024 CMD8: index 8, arg 0x000001AA, type 01; card model replies 0x08000001AA13 after 5 bit periods -> resp_data=0x08000001AA; no errors.
REQ-025 Same as REQ-024, but the reply CRC is corrupted to 0x14 -> crc_err=1 (macro defined) or crc_err=0 (macro undefined).
REQ-026 Type 01 with cmd_in held high -> timeout_err=1 and done pulse exactly 128 cycles after SEND ends; busy low 16 cycles later.
REQ-027 R2 reply from the card model with end bit forced to 0 -> end_err=1 and resp_data matches bits [127:0].
REQ-028 rst asserted at SEND bit 20 -> cmd_oe=0 and busy=0 immediately; a new CMD0 start after release gives a correct full frame.
